// File: rtl/conv4_psum_accum_if.sv
// conv4_psum_accum_if: handshake bundle between the conv4 PE-row psum source,
// the accumulation/requantisation stage and the activation write-back consumer.
// The master side is the environment (psum source + consumer); the slave side
// is conv4_psum_accum itself.
interface conv4_psum_accum_if #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 24
);
   // psum input channel
   logic                  psum_valid;
   logic                  psum_ready;
   logic [2*DATA_W-1:0]   psum_in;
   logic [ACC_W-1:0]      bias;
   logic [4:0]            shift;

   // requantised pixel output channel
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_W-1:0]     out_data;

   // status
   logic                  busy;
   logic                  sat_flag;

   modport master (
      output psum_valid, psum_in, bias, shift, out_ready,
      input  psum_ready, out_valid, out_data, busy, sat_flag
   );

   modport slave (
      input  psum_valid, psum_in, bias, shift, out_ready,
      output psum_ready, out_valid, out_data, busy, sat_flag
   );
endinterface

// File: rtl/conv4_psum_accum.sv
// conv4_psum_accum: accumulates NUM_TERMS signed partial sums per output pixel,
// adds the per-pixel bias, rounds half-up, arithmetic-shifts and saturates to
// DATA_W bits, then queues the pixel in a first-word-fall-through FIFO.
// Build option: define RELU4_EN to clamp negative results to zero before
// saturation (negatives then never raise sat_flag).
module conv4_psum_accum #(
   parameter int DATA_W     = 8,
   parameter int ACC_W      = 24,
   parameter int NUM_TERMS  = 9,
   parameter int FIFO_DEPTH = 4
) (
   input logic                clk,
   input logic                rstn,
   conv4_psum_accum_if.slave  bus
);

   // ------------------------------------------------------------------
   // Local constants
   // ------------------------------------------------------------------
   localparam int CNT_W = $clog2(NUM_TERMS + 1);
   localparam int PTR_W = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ACC   = 2'd1;
   localparam logic [1:0] S_QUANT = 2'd2;
   localparam logic [1:0] S_PUSH  = 2'd3;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TERMS - 1);

   // One extra bit of headroom so the rounding constant never overflows
   localparam logic signed [ACC_W:0] RND_ONE = {{ACC_W{1'b0}}, 1'b1};
   localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(2**(DATA_W-1) - 1);
   localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

   // ------------------------------------------------------------------
   // Requantisation: round half up, arithmetic shift, optional ReLU,
   // saturate. Returns {clamped, value}.
   // ------------------------------------------------------------------
   function automatic logic [DATA_W:0] requant_f(
      input logic signed [ACC_W-1:0] acc_v,
      input logic        [4:0]       sh_v
   );
      logic signed [ACC_W:0] ext_v;
      logic signed [ACC_W:0] rnd_v;
      logic signed [ACC_W:0] shr_v;
      logic        [DATA_W:0] res_v;
      ext_v = {acc_v[ACC_W-1], acc_v};
      if (sh_v == 5'd0) begin
         rnd_v = '0;
      end else begin
         rnd_v = RND_ONE << (sh_v - 5'd1);
      end
      shr_v = (ext_v + rnd_v) >>> sh_v;
`ifdef RELU4_EN
      shr_v = shr_v[ACC_W] ? '0 : shr_v;
`endif
      if (shr_v > SAT_MAX) begin
         res_v = {1'b1, SAT_MAX[DATA_W-1:0]};
      end else if (shr_v < SAT_MIN) begin
         res_v = {1'b1, SAT_MIN[DATA_W-1:0]};
      end else begin
         res_v = {1'b0, shr_v[DATA_W-1:0]};
      end
      return res_v;
   endfunction

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [1:0]              state_q, state_d;
   logic [ACC_W-1:0]        acc_q,   acc_d;
   logic [CNT_W-1:0]        cnt_q,   cnt_d;
   logic [4:0]              shift_q, shift_d;
   logic [DATA_W-1:0]       res_q,   res_d;
   logic                    sat_q,   sat_d;
   logic                    ready_q, ready_d;

   logic [DATA_W-1:0]       mem_q [FIFO_DEPTH];
   logic [PTR_W:0]          wr_ptr_q;
   logic [PTR_W:0]          rd_ptr_q;

   logic                    xfer_s;
   logic                    push_s;
   logic                    pop_s;
   logic                    full_s;
   logic                    empty_s;
   logic [ACC_W-1:0]        psum_ext_s;
   logic [DATA_W:0]         quant_s;

   // ------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------
   assign xfer_s     = bus.psum_valid & ready_q;
   assign psum_ext_s = {{(ACC_W - 2*DATA_W){bus.psum_in[2*DATA_W-1]}}, bus.psum_in};
   assign quant_s    = requant_f(acc_q, shift_q);

   assign empty_s = (wr_ptr_q == rd_ptr_q);
   assign full_s  = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) &&
                    (wr_ptr_q[PTR_W]     != rd_ptr_q[PTR_W]);
   assign pop_s   = ~empty_s & bus.out_ready;

   // Next-state logic of the accumulate / requantise / push sequencer
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      res_d   = res_q;
      sat_d   = sat_q;
      push_s  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (xfer_s) begin
               acc_d   = bus.bias + psum_ext_s;
               shift_d = bus.shift;
               cnt_d   = CNT_W'(1);
               state_d = (NUM_TERMS == 1) ? S_QUANT : S_ACC;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ACC: begin
            if (xfer_s) begin
               // Accumulator wraps silently; ACC_W is sized to avoid it
               acc_d = acc_q + psum_ext_s;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_CNT) begin
                  state_d = S_QUANT;
               end else begin
                  state_d = S_ACC;
               end
            end else begin
               state_d = S_ACC;
            end
         end
         S_QUANT: begin
            res_d   = quant_s[DATA_W-1:0];
            if (quant_s[DATA_W]) begin
               sat_d = 1'b1;
            end else begin
               sat_d = sat_q;
            end
            state_d = S_PUSH;
         end
         S_PUSH: begin
            // Full is checked in this same cycle, so a push never meets a
            // pop on a full FIFO
            if (!full_s) begin
               push_s  = 1'b1;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               state_d = S_PUSH;
            end
         end
         default: begin
            state_d = S_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
         end
      endcase
      // Ready is registered so it stays low through reset and rises one
      // cycle after release
      ready_d = (state_d == S_IDLE) || (state_d == S_ACC);
   end

   // Sequencer, accumulator and status registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         shift_q <= 5'd0;
         res_q   <= '0;
         sat_q   <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         res_q   <= res_d;
         sat_q   <= sat_d;
         ready_q <= ready_d;
      end
   end

   // Output FIFO storage and pointers (extra pointer bit separates full/empty)
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (push_s) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= res_q;
            wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
         end
         if (pop_s) begin
            rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs (all decoded directly from registers)
   // ------------------------------------------------------------------
   assign bus.psum_ready = ready_q;
   assign bus.out_valid  = ~empty_s;
   assign bus.out_data   = empty_s ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];
   assign bus.busy       = (state_q != S_IDLE);
   assign bus.sat_flag   = sat_q;

endmodule

// File: tb/tb_conv4_psum_accum.sv
// tb_conv4_psum_accum: scoreboard bench for conv4_psum_accum.
// Expected pixels are computed by an independent model and queued when a
// pixel is driven; a negedge monitor pops and compares on each output handshake.
module tb_conv4_psum_accum;

   localparam int DATA_W = 8;
   localparam int ACC_W  = 24;
   localparam int NT     = 9;
   localparam int FD     = 4;

   logic clk;
   logic rstn;

   conv4_psum_accum_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) ifc ();

   conv4_psum_accum #(
      .DATA_W(DATA_W), .ACC_W(ACC_W), .NUM_TERMS(NT), .FIFO_DEPTH(FD)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (ifc)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int n_out    = 0;
   int ordy_mode = 0;   // 0: out_ready=1, 1: random, 2: out_ready=0
   int sb_q[$];

   // clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // independent reference: bias + sum, wrap at ACC_W, round half up, shift, clamp
   function automatic int model_px(input int bias, input int sh, input int ps[NT]);
      longint s;
      logic signed [ACC_W-1:0] w;
      s = bias;
      for (int i = 0; i < NT; i++) s += ps[i];
      w = s[ACC_W-1:0];
      s = w;
      if (sh > 0) s = s + (longint'(1) << (sh - 1));
      s = s >>> sh;
`ifdef RELU4_EN
      if (s < 0) s = 0;
`endif
      if (s > 127) s = 127;
      if (s < -128) s = -128;
      return int'(s);
   endfunction

   // out_ready driver, updated just after each rising edge
   initial begin
      ifc.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ordy_mode)
            0:       ifc.out_ready = 1'b1;
            1:       ifc.out_ready = 1'($urandom_range(0, 1));
            default: ifc.out_ready = 1'b0;
         endcase
      end
   end

   // scoreboard monitor
   initial begin
      forever begin
         @(negedge clk);
         if (rstn && ifc.out_valid && ifc.out_ready) begin
            n_out++;
            if (sb_q.size() == 0) begin
               check_eq("sb_unexpected_out", int'(ifc.out_valid), 0);
            end else begin
               check_eq("sb_data", int'($signed(ifc.out_data)), sb_q.pop_front());
            end
         end
      end
   end

   // one term: optional idle gap, then hold valid until accepted
   task automatic send_term(input int p, input int max_gap);
      int  g;
      int  t;
      bit  rdy;
      bit  done;
      g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      ifc.psum_valid = 1'b0;
      repeat (g) begin @(posedge clk); #1; end
      ifc.psum_valid = 1'b1;
      ifc.psum_in    = 16'(p);
      t = 0;
      done = 1'b0;
      while (!done) begin
         @(negedge clk);
         rdy = ifc.psum_ready;
         @(posedge clk);
         #1;
         if (rdy) begin
            done = 1'b1;
         end else begin
            t++;
            if (t > 300) begin
               check_eq("psum_accept_timeout", t, 0);
               done = 1'b1;
            end
         end
      end
      ifc.psum_valid = 1'b0;
   endtask

   // whole pixel; bias/shift are scrambled after the first term
   task automatic send_pixel(input int bias, input int sh, input int ps[NT], input int max_gap);
      sb_q.push_back(model_px(bias, sh, ps));
      ifc.bias  = 24'(bias);
      ifc.shift = 5'(sh);
      for (int i = 0; i < NT; i++) begin
         send_term(ps[i], max_gap);
         ifc.bias  = 24'($urandom);
         ifc.shift = 5'($urandom_range(0, 23));
      end
   endtask

   task automatic wait_drain(input string tag);
      int t;
      t = 0;
      while ((sb_q.size() != 0 || ifc.out_valid) && t < 3000) begin
         @(posedge clk); #1; t++;
      end
      check_eq(tag, sb_q.size(), 0);
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      sb_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
   endtask

   int ps[NT];
   int lat;
   int n_before;

   initial begin
      rstn           = 1'b0;
      ifc.psum_valid = 1'b1;
      ifc.psum_in    = 16'd0;
      ifc.bias       = 24'd0;
      ifc.shift      = 5'd0;

      // 1: reset values, ready rises one cycle after release
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_psum_ready", int'(ifc.psum_ready), 0);
      check_eq("rst_out_valid",  int'(ifc.out_valid), 0);
      check_eq("rst_out_data",   int'(ifc.out_data), 0);
      check_eq("rst_busy",       int'(ifc.busy), 0);
      check_eq("rst_sat",        int'(ifc.sat_flag), 0);
      @(negedge clk);
      rstn = 1'b1;
      #1;
      check_eq("rel_ready_low", int'(ifc.psum_ready), 0);
      ifc.psum_valid = 1'b0;
      @(posedge clk);
      #1;
      check_eq("rel_ready_high", int'(ifc.psum_ready), 1);

      // 2: 9 x 10, bias 5, shift 2 -> 24, latency 3 cycles
      for (int i = 0; i < NT; i++) ps[i] = 10;
      send_pixel(5, 2, ps, 0);
      check_eq("busy_after_last", int'(ifc.busy), 1);
      lat = 1;
      while (!ifc.out_valid && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
      check_eq("latency", lat, 3);
      wait_drain("drain_t2");
      check_eq("sat_t2", int'(ifc.sat_flag), 0);

      // 3: positive and negative saturation
      for (int i = 0; i < NT; i++) ps[i] = 1000;
      send_pixel(0, 0, ps, 0);
      wait_drain("drain_t3p");
      check_eq("sat_pos", int'(ifc.sat_flag), 1);
      do_reset();
      check_eq("sat_cleared", int'(ifc.sat_flag), 0);
      for (int i = 0; i < NT; i++) ps[i] = -1000;
      send_pixel(0, 0, ps, 0);
      wait_drain("drain_t3n");
`ifdef RELU4_EN
      check_eq("sat_neg", int'(ifc.sat_flag), 0);
`else
      check_eq("sat_neg", int'(ifc.sat_flag), 1);
`endif
      do_reset();

      // 4: backpressure, 5 pixels with out_ready held low
      ordy_mode = 2;
      @(posedge clk); #1;
      for (int k = 1; k <= 5; k++) begin
         for (int i = 0; i < NT; i++) ps[i] = k;
         send_pixel(k, 0, ps, 0);
      end
      repeat (5) begin @(posedge clk); #1; end
      check_eq("bp_busy",     int'(ifc.busy), 1);
      check_eq("bp_ready",    int'(ifc.psum_ready), 0);
      check_eq("bp_valid",    int'(ifc.out_valid), 1);
      check_eq("bp_head",     int'($signed(ifc.out_data)), 10);
      n_before = n_out;
      ordy_mode = 0;
      wait_drain("drain_t4");
      check_eq("bp_count", n_out - n_before, 5);

      // 5: random traffic, 200 pixels
      ordy_mode = 1;
      for (int k = 0; k < 200; k++) begin
         for (int i = 0; i < NT; i++) ps[i] = int'($urandom_range(0, 4000)) - 2000;
         send_pixel(int'($urandom_range(0, 10000)) - 5000, int'($urandom_range(0, 23)), ps, 2);
      end
      ordy_mode = 0;
      wait_drain("drain_t5");

      // 6: reset mid-pixel with words in the FIFO
      ordy_mode = 2;
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < NT; i++) ps[i] = 20 + k;
         send_pixel(3, 1, ps, 0);
      end
      ifc.bias  = 24'd100;
      ifc.shift = 5'd0;
      for (int i = 0; i < 4; i++) send_term(50, 0);
      check_eq("pre_rst_valid", int'(ifc.out_valid), 1);
      check_eq("pre_rst_busy",  int'(ifc.busy), 1);
      rstn = 1'b0;
      sb_q.delete();
      #1;
      check_eq("mid_rst_valid", int'(ifc.out_valid), 0);
      check_eq("mid_rst_busy",  int'(ifc.busy), 0);
      check_eq("mid_rst_data",  int'(ifc.out_data), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      ordy_mode = 0;
      @(posedge clk); #1;
      n_before = n_out;
      for (int i = 0; i < NT; i++) ps[i] = 3;
      send_pixel(7, 0, ps, 0);
      wait_drain("drain_t6");
      check_eq("post_rst_count", n_out - n_before, 1);

      check_eq("sb_final_empty", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
